// File: rtl/fifo_widen_pkg.sv
// fifo_widen_pkg: constants shared by the packing FIFO and its controller.
//   ELEMS_PER_WORD - narrow elements packed into one output word.
package fifo_widen_pkg;
  localparam int unsigned ELEMS_PER_WORD = 2;
endpackage

// File: rtl/fifo_widen_ctrl.sv
// fifo_widen_ctrl: pointer and occupancy control for the narrow-in,
// wide-out FIFO. Counts stored elements; a read consumes a whole pair.
// Ports:
//   clk, reset      - rising-edge clock, async active-high reset
//   wr, rd          - raw write / read requests
//   w_addr, r_addr  - element write address, head-pair base address (even)
//   wr_en           - qualified write enable for the storage array
//   empty, full     - fewer than one pair stored / storage completely used
//   count           - stored elements, 0..DEPTH
module fifo_widen_ctrl
  import fifo_widen_pkg::*;
#(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic                  rd,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  wr_en,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   count
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [ADDR_WIDTH-1:0] w_ptr;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic                  rd_en;

  // Status comes only from the registered count, never from rd/wr.
  assign empty = (count < (ADDR_WIDTH+1)'(ELEMS_PER_WORD));
  assign full  = (count == (ADDR_WIDTH+1)'(DEPTH));

  // A write into a full FIFO is accepted when a read frees space that edge.
  assign rd_en = rd & ~empty;
  assign wr_en = wr & (~full | rd_en);

  assign w_addr = w_ptr;
  assign r_addr = r_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_ptr <= '0;
      r_ptr <= '0;
      count <= '0;
    end else begin
      if (wr_en)
        w_ptr <= w_ptr + ADDR_WIDTH'(1);
      // r_ptr stays even, so a pair never straddles the wrap point.
      if (rd_en)
        r_ptr <= r_ptr + ADDR_WIDTH'(ELEMS_PER_WORD);
      case ({wr_en, rd_en})
        2'b10:   count <= count + (ADDR_WIDTH+1)'(1);
        2'b01:   count <= count - (ADDR_WIDTH+1)'(ELEMS_PER_WORD);
        2'b11:   count <= count - (ADDR_WIDTH+1)'(ELEMS_PER_WORD - 1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/fifo_widen.sv
// fifo_widen: narrow-in, wide-out first-word-fall-through FIFO.
// Each write stores one DATA_WIDTH element; each read pops a pair, shown as
// {later element, earlier element} on r_data while empty is low.
// Ports:
//   clk, reset - rising-edge clock, async active-high reset
//   wr, w_data - push one element
//   rd         - pop the head pair currently shown on r_data
//   r_data     - head pair, zero while empty
//   empty      - no complete pair stored
//   full       - DEPTH elements stored
//   count      - stored elements, 0..DEPTH
module fifo_widen
  import fifo_widen_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 wr,
  input  logic                                 rd,
  input  logic [DATA_WIDTH-1:0]                w_data,
  output logic [ELEMS_PER_WORD*DATA_WIDTH-1:0] r_data,
  output logic                                 empty,
  output logic                                 full,
  output logic [ADDR_WIDTH:0]                  count
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_addr_hi;
  logic                  wr_en;

  fifo_widen_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ctrl (
    .clk    (clk),
    .reset  (reset),
    .wr     (wr),
    .rd     (rd),
    .w_addr (w_addr),
    .r_addr (r_addr),
    .wr_en  (wr_en),
    .empty  (empty),
    .full   (full),
    .count  (count)
  );

  // Storage is deliberately not reset; r_data gating hides stale contents.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[w_addr] <= w_data;
  end

  assign r_addr_hi = r_addr + ADDR_WIDTH'(1);
  assign r_data    = empty ? '0 : {mem[r_addr_hi], mem[r_addr]};
endmodule

// File: tb/tb_fifo_widen.sv
module tb_fifo_widen;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wr = 1'b0;
  logic        rd = 1'b0;
  logic [7:0]  w_data = '0;
  logic [15:0] r_data;
  logic        empty;
  logic        full;
  logic [4:0]  count;

  int total = 0;
  int bad = 0;
  logic [7:0] q[$];

  fifo_widen #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .wr     (wr),
    .rd     (rd),
    .w_data (w_data),
    .r_data (r_data),
    .empty  (empty),
    .full   (full),
    .count  (count)
  );

  always #5 clk = ~clk;

  // Reference: element queue; a read takes two from the front.
  function automatic logic [15:0] exp_head();
    if (q.size() >= 2) return {q[1], q[0]};
    return 16'h0000;
  endfunction

  task automatic step(input bit w, input bit r, input logic [7:0] d);
    int n;
    bit re, we;
    wr = w; rd = r; w_data = d;
    n  = q.size();
    re = r && (n >= 2);
    we = w && ((n < 16) || re);
    @(posedge clk);
    if (re) begin
      void'(q.pop_front());
      void'(q.pop_front());
    end
    if (we) q.push_back(d);
    #1;
    wr = 1'b0; rd = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    total++;
    if (empty !== 1'b1 || full !== 1'b0 || count !== 5'd0 || r_data !== 16'h0000) begin
      bad++;
      $display("FAIL reset_async: empty=%b full=%b count=%0d r_data=%h want 1 0 0 0000", empty, full, count, r_data);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete();
    total++;
    if (empty !== 1'b1 || full !== 1'b0 || count !== 5'd0 || r_data !== 16'h0000) begin
      bad++;
      $display("FAIL reset_state: empty=%b full=%b count=%0d r_data=%h want 1 0 0 0000", empty, full, count, r_data);
    end
  endtask

  task automatic test_pair();
    step(1, 0, 8'h01);
    total++;
    if (count !== 5'd1 || empty !== 1'b1 || r_data !== 16'h0000) begin
      bad++;
      $display("FAIL pair_odd: count=%0d empty=%b r_data=%h want 1 1 0000", count, empty, r_data);
    end
    step(1, 0, 8'h02);
    total++;
    if (count !== 5'd2 || empty !== 1'b0 || r_data !== 16'h0201) begin
      bad++;
      $display("FAIL pair_full: count=%0d empty=%b r_data=%h want 2 0 0201", count, empty, r_data);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 8'h00);
      total++;
      if (r_data !== 16'h0201 || empty !== 1'b0) begin
        bad++;
        $display("FAIL pair_hold%0d: r_data=%h empty=%b want 0201 0", i, r_data, empty);
      end
    end
  endtask

  task automatic test_fill_drain();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 8'(i));
      total++;
      if (count !== 5'(i + 1) || full !== (i == 15)) begin
        bad++;
        $display("FAIL fill%0d: count=%0d full=%b want %0d %b", i, count, full, i + 1, i == 15);
      end
    end
    step(1, 0, 8'hAA);
    total++;
    if (count !== 5'd16 || full !== 1'b1 || r_data !== 16'h0100) begin
      bad++;
      $display("FAIL overflow: count=%0d full=%b r_data=%h want 16 1 0100", count, full, r_data);
    end
    for (int i = 0; i < 8; i++) begin
      logic [15:0] want;
      want = {8'(2*i + 1), 8'(2*i)};
      total++;
      if (r_data !== want || r_data !== exp_head()) begin
        bad++;
        $display("FAIL drain%0d: r_data=%h want %h", i, r_data, want);
      end
      step(0, 1, 8'h00);
    end
    total++;
    if (empty !== 1'b1 || count !== 5'd0 || r_data !== 16'h0000) begin
      bad++;
      $display("FAIL drained: empty=%b count=%0d r_data=%h want 1 0 0000", empty, count, r_data);
    end
    step(0, 1, 8'h00);
    total++;
    if (empty !== 1'b1 || count !== 5'd0 || full !== 1'b0) begin
      bad++;
      $display("FAIL rd_empty: empty=%b count=%0d full=%b want 1 0 0", empty, count, full);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 6; i++) step(1, 0, 8'(8'h10 + i));
    for (int i = 0; i < 3; i++) begin
      total++;
      if (r_data !== {8'(8'h11 + 2*i), 8'(8'h10 + 2*i)}) begin
        bad++;
        $display("FAIL wrap_pre%0d: r_data=%h want %h", i, r_data, {8'(8'h11 + 2*i), 8'(8'h10 + 2*i)});
      end
      step(0, 1, 8'h00);
    end
    for (int i = 0; i < 16; i++) step(1, 0, 8'(8'h20 + i));
    total++;
    if (full !== 1'b1 || count !== 5'd16) begin
      bad++;
      $display("FAIL wrap_full: full=%b count=%0d want 1 16", full, count);
    end
    for (int i = 0; i < 8; i++) begin
      logic [15:0] want;
      want = {8'(8'h21 + 2*i), 8'(8'h20 + 2*i)};
      total++;
      if (r_data !== want) begin
        bad++;
        $display("FAIL wrap_rd%0d: r_data=%h want %h", i, r_data, want);
      end
      step(0, 1, 8'h00);
    end
    total++;
    if (empty !== 1'b1 || count !== 5'd0) begin
      bad++;
      $display("FAIL wrap_end: empty=%b count=%0d want 1 0", empty, count);
    end
  endtask

  task automatic test_simul();
    do_reset();
    for (int i = 0; i < 16; i++) step(1, 0, 8'($urandom));
    step(1, 1, 8'h55);
    total++;
    if (count !== 5'd15 || full !== 1'b0 || r_data !== exp_head() || q[14] !== 8'h55) begin
      bad++;
      $display("FAIL simul_full: count=%0d full=%b r_data=%h want 15 0 %h", count, full, r_data, exp_head());
    end
    do_reset();
    step(1, 0, 8'h33);
    step(1, 1, 8'h44);
    total++;
    if (count !== 5'd2 || empty !== 1'b0 || r_data !== 16'h4433) begin
      bad++;
      $display("FAIL simul_one: count=%0d empty=%b r_data=%h want 2 0 4433", count, empty, r_data);
    end
    step(1, 1, 8'h66);
    total++;
    if (count !== 5'd1 || empty !== 1'b1 || r_data !== 16'h0000) begin
      bad++;
      $display("FAIL simul_two: count=%0d empty=%b r_data=%h want 1 1 0000", count, empty, r_data);
    end
    step(1, 0, 8'h77);
    step(1, 0, 8'h88);
    step(1, 1, 8'h99);
    total++;
    if (count !== 5'd2 || r_data !== 16'h9988) begin
      bad++;
      $display("FAIL simul_three: count=%0d r_data=%h want 2 9988", count, r_data);
    end
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      bit w, r;
      // Phase-dependent bias so both full and empty regions are visited.
      if ((i / 50) % 2 == 0) begin
        w = ($urandom_range(0, 9) < 8);
        r = ($urandom_range(0, 9) < 2);
      end else begin
        w = ($urandom_range(0, 9) < 6);
        r = ($urandom_range(0, 9) < 5);
      end
      step(w, r, 8'($urandom));
      total++;
      if (count !== 5'(q.size()) || empty !== (q.size() < 2) ||
          full !== (q.size() == 16) || r_data !== exp_head()) begin
        bad++;
        errs++;
        if (errs <= 5)
          $display("FAIL random%0d: count=%0d empty=%b full=%b r_data=%h want %0d %b %b %h",
                   i, count, empty, full, r_data, q.size(), q.size() < 2, q.size() == 16, exp_head());
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 0, 8'(8'hC0 + i));
    total++;
    if (count !== 5'd5 || r_data !== 16'hC1C0) begin
      bad++;
      $display("FAIL mid_pre: count=%0d r_data=%h want 5 c1c0", count, r_data);
    end
    reset = 1'b1;
    #1;
    total++;
    if (empty !== 1'b1 || count !== 5'd0 || full !== 1'b0 || r_data !== 16'h0000) begin
      bad++;
      $display("FAIL mid_reset: empty=%b count=%0d full=%b r_data=%h want 1 0 0 0000", empty, count, full, r_data);
    end
    #1;
    reset = 1'b0;
    q.delete();
    step(1, 0, 8'h77);
    step(1, 0, 8'h88);
    total++;
    if (r_data !== 16'h8877 || count !== 5'd2 || empty !== 1'b0) begin
      bad++;
      $display("FAIL mid_after: r_data=%h count=%0d empty=%b want 8877 2 0", r_data, count, empty);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_pair();
    test_fill_drain();
    test_wrap();
    test_simul();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
